// File: rtl/ex_mem.sv
// EX/MEM pipeline register: captures execute-stage results and the remaining
// memory/writeback controls, with synchronous flush-to-bubble and async clear.
module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_Flush,
  input  logic        RegWrite_in,
  input  logic        MemtoReg_in,
  input  logic        Branch_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Jump_in,
  input  logic [31:0] jump_addr_in,
  input  logic [31:0] branch_addr_in,
  input  logic        ALU_zero_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] reg_read_data_2_in,
  input  logic [4:0]  ID_EX_RegisterRd_in,
  output logic        RegWrite_out,
  output logic        MemtoReg_out,
  output logic        Branch_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        Jump_out,
  output logic [31:0] jump_addr_out,
  output logic [31:0] branch_addr_out,
  output logic        ALU_zero_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] reg_read_data_2_out,
  output logic [4:0]  EX_MEM_RegisterRd_out
);

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // EX -> MEM stage boundary; a flush clears data too so the bubble is all-zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 1'b0;
      Branch_out            <= 1'b0;
      MemRead_out           <= 1'b0;
      MemWrite_out          <= 1'b0;
      Jump_out              <= 1'b0;
      jump_addr_out         <= '0;
      branch_addr_out       <= '0;
      ALU_zero_out          <= 1'b0;
      ALU_result_out        <= '0;
      reg_read_data_2_out   <= '0;
      EX_MEM_RegisterRd_out <= '0;
    end else if (EX_Flush) begin
      RegWrite_out          <= 1'b0;
      MemtoReg_out          <= 1'b0;
      Branch_out            <= 1'b0;
      MemRead_out           <= 1'b0;
      MemWrite_out          <= 1'b0;
      Jump_out              <= 1'b0;
      jump_addr_out         <= {DATA_W{1'b0}};
      branch_addr_out       <= {DATA_W{1'b0}};
      ALU_zero_out          <= 1'b0;
      ALU_result_out        <= {DATA_W{1'b0}};
      reg_read_data_2_out   <= {DATA_W{1'b0}};
      EX_MEM_RegisterRd_out <= {REG_W{1'b0}};
    end else begin
      RegWrite_out          <= RegWrite_in;
      MemtoReg_out          <= MemtoReg_in;
      Branch_out            <= Branch_in;
      MemRead_out           <= MemRead_in;
      MemWrite_out          <= MemWrite_in;
      Jump_out              <= Jump_in;
      jump_addr_out         <= jump_addr_in;
      branch_addr_out       <= branch_addr_in;
      ALU_zero_out          <= ALU_zero_in;
      ALU_result_out        <= ALU_result_in;
      reg_read_data_2_out   <= reg_read_data_2_in;
      EX_MEM_RegisterRd_out <= ID_EX_RegisterRd_in;
    end
  end

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed steps from the test plan followed by a random
// soak against a one-cycle register model with async clear and flush-to-zero.
module tb_ex_mem;

  localparam int VW = 140;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        EX_Flush = 1'b0;
  logic        RegWrite_in = 1'b0, MemtoReg_in = 1'b0, Branch_in = 1'b0;
  logic        MemRead_in = 1'b0, MemWrite_in = 1'b0, Jump_in = 1'b0;
  logic [31:0] jump_addr_in = '0, branch_addr_in = '0;
  logic        ALU_zero_in = 1'b0;
  logic [31:0] ALU_result_in = '0, reg_read_data_2_in = '0;
  logic [4:0]  ID_EX_RegisterRd_in = '0;
  logic        RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Jump_out;
  logic [31:0] jump_addr_out, branch_addr_out;
  logic        ALU_zero_out;
  logic [31:0] ALU_result_out, reg_read_data_2_out;
  logic [4:0]  EX_MEM_RegisterRd_out;

  ex_mem dut (
    .clk(clk), .rst(rst), .EX_Flush(EX_Flush),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .Branch_in(Branch_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Jump_in(Jump_in),
    .jump_addr_in(jump_addr_in), .branch_addr_in(branch_addr_in),
    .ALU_zero_in(ALU_zero_in), .ALU_result_in(ALU_result_in),
    .reg_read_data_2_in(reg_read_data_2_in), .ID_EX_RegisterRd_in(ID_EX_RegisterRd_in),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out), .Branch_out(Branch_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out), .Jump_out(Jump_out),
    .jump_addr_out(jump_addr_out), .branch_addr_out(branch_addr_out),
    .ALU_zero_out(ALU_zero_out), .ALU_result_out(ALU_result_out),
    .reg_read_data_2_out(reg_read_data_2_out), .EX_MEM_RegisterRd_out(EX_MEM_RegisterRd_out)
  );

  always #5 clk = ~clk;

  // Whole-stage views: the model treats the register as one opaque word.
  logic [VW-1:0] in_vec, out_vec, exp_q, saved;
  assign in_vec  = {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in,
                    jump_addr_in, branch_addr_in, ALU_zero_in, ALU_result_in,
                    reg_read_data_2_in, ID_EX_RegisterRd_in};
  assign out_vec = {RegWrite_out, MemtoReg_out, Branch_out, MemRead_out, MemWrite_out, Jump_out,
                    jump_addr_out, branch_addr_out, ALU_zero_out, ALU_result_out,
                    reg_read_data_2_out, EX_MEM_RegisterRd_out};

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [VW-1:0] v);
    {RegWrite_in, MemtoReg_in, Branch_in, MemRead_in, MemWrite_in, Jump_in,
     jump_addr_in, branch_addr_in, ALU_zero_in, ALU_result_in,
     reg_read_data_2_in, ID_EX_RegisterRd_in} = v;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[VW-1:0];
  endfunction

  // Advance one rising edge, update the model from what was sampled, check at edge+1.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst || EX_Flush) exp_q = '0;
    else                 exp_q = in_vec;
    #1 check(tag, out_vec, exp_q);
  endtask

  initial begin
    exp_q = '0;
    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1 check("reset_init", out_vec, '0);
    tick("reset_hold_edge");

    // Reset pulse between edges with all inputs at ones
    set_in('1);
    #3 rst = 1'b0;
    tick("ones_load");
    #3 rst = 1'b1;
    exp_q = '0;
    #1 check("async_clear", out_vec, exp_q);
    tick("rst_hold_ones_1");
    EX_Flush = 1'b0;
    tick("rst_hold_ones_2");
    #3 rst = 1'b0;
    #1 check("rst_release_no_edge", out_vec, '0);
    tick("release_loads_ones");
    check32("rd_31", {27'd0, EX_MEM_RegisterRd_out}, 32'd31);
    check32("alu_ones", ALU_result_out, 32'hFFFF_FFFF);

    // Normal load from the test plan
    set_in('0);
    RegWrite_in = 1'b1; MemRead_in = 1'b1;
    ALU_result_in = 32'h0000_1234; reg_read_data_2_in = 32'hDEAD_BEEF;
    jump_addr_in = 32'h0040_0010; branch_addr_in = 32'h0040_0020;
    ALU_zero_in = 1'b1; ID_EX_RegisterRd_in = 5'd17;
    tick("normal_load");
    check32("normal_alu", ALU_result_out, 32'h0000_1234);
    check32("normal_ctrl", {26'd0, RegWrite_out, MemtoReg_out, Branch_out, MemRead_out,
                            MemWrite_out, Jump_out}, 32'b100100);

    // Flush wins over valid inputs, then normal load resumes
    EX_Flush = 1'b1;
    tick("flush");
    check32("flush_rd", {27'd0, EX_MEM_RegisterRd_out}, 32'd0);
    EX_Flush = 1'b0;
    tick("after_flush");

    // Flush glitch not spanning an edge, and inputs changing mid-cycle
    saved = in_vec;
    #2 EX_Flush = 1'b1;
    #2 EX_Flush = 1'b0;
    set_in(rand_vec());
    #1 check("glitch_no_effect", out_vec, exp_q);
    set_in(saved);
    tick("after_glitch");

    // Pipelining: one value per edge, each lagging by one edge
    for (int i = 1; i <= 4; i++) begin
      ALU_result_in = 32'(i);
      tick("pipe");
      check32("pipe_alu", ALU_result_out, 32'(i));
    end

    // Random soak with mid-cycle reset assertion/release and random flush
    for (int c = 0; c < 2500; c++) begin
      set_in(rand_vec());
      EX_Flush = ($urandom_range(0, 3) == 0);
      if (!rst && $urandom_range(0, 15) == 0) begin
        #3 rst = 1'b1;
        exp_q = '0;
        #1 check("soak_async_clear", out_vec, exp_q);
      end else if (rst && $urandom_range(0, 2) == 0) begin
        #3 rst = 1'b0;
        #1 check("soak_release", out_vec, exp_q);
      end
      tick("soak");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
